shift_cmd_sequencer: RTL and testbench
======================================

// Module: shift_cmd_sequencer
// PURPOSE
//  Upstream command stage for the 8-bit combinational right barrel shifter (rotate/logic/arith).
//  Buffers shift commands {data, amt, lar} in a DEPTH-entry FIFO.
//  Drives the FIFO head onto the shifter inputs from registers, so the shifter sees glitch-free operands.
//  Captures the shifter result in an output register with a valid/ready handshake to the consumer.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, 2..16. Total in-flight capacity = DEPTH + 1 (FIFO + output register).
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst_n      in   1  reset; asynchronous assert, active-low
//  flush      in   1  synchronous clear of FIFO and output register
//  in_valid   in   1  upstream command valid
//  in_ready   out  1  command accepted when in_valid & in_ready at the rising edge
//  in_a       in   8  operand to shift
//  in_amt     in   3  shift amount 0..7
//  in_lar     in   2  00 logic, 01 arith, 1x rotate (shifter encoding)
//  sh_a       out  8  to shifter operand; equals FIFO head data
//  sh_amt     out  3  to shifter amount; equals FIFO head amt
//  sh_lar     out  2  to shifter mode; equals FIFO head lar
//  sh_o       in   8  shifter result (combinational function of sh_a/sh_amt/sh_lar)
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer takes result when out_valid & out_ready at the rising edge
//  out_data   out  8  captured shifter result
//  out_lar    out  2  mode of the command that produced out_data
//  count      out  5  number of commands held in the FIFO (0..DEPTH); excludes the output register
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): FIFO empty, read/write pointers 0, count=0.
//   - Reset takes effect immediately, including mid-operation; all buffered commands are lost.
//   - Output values during and after reset: out_valid=0, out_data=0, out_lar=0, sh_a=0, sh_amt=0, sh_lar=0.
//   - in_ready=1 on the first cycle after reset release.
//  in_ready = !full & !flush.
//   - Push and pop in the same cycle are allowed when the FIFO is neither full nor empty.
//   - When the FIFO is full, no push is accepted, even if a pop occurs in the same cycle (no bypass).
//   - When the FIFO is empty, a push is never forwarded to the shifter in the same cycle.
//  sh_* outputs:
//   - Driven from the head storage entry (registered path).
//   - Forced to 0 when the FIFO is empty.
//  Output register FSM, two states:
//   - EMPTY (out_valid=0): if count>0, capture sh_o into out_data and head lar into out_lar, pop head, go to FULL.
//   - FULL (out_valid=1):
//     - out_ready=1 & count>0: capture the next head and pop; stay FULL (back-to-back, 1 result/cycle).
//     - out_ready=1 & count=0: go to EMPTY.
//     - out_ready=0: hold out_data and out_lar stable; no pop.
//  Latency: a command accepted at edge t appears with out_valid=1 after edge t+1, provided the pipeline is idle.
//  Ordering: strict FIFO; every accepted command yields exactly one result, in order, unless flush or reset intervenes.
//  Pointers: log2(DEPTH) bits, wrap modulo DEPTH. The full/empty decision uses count, not pointer equality.
//  count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
//  flush=1 at an edge:
//   - Clears count, pointers and out_valid; out_data and out_lar are unchanged.
//   - Push and pop are ignored on that edge, and in_ready=0 while flush=1.
//  The block does no arithmetic on data. amt and lar are passed unmodified; illegal encodings do not exist.
// TESTING
//  1. Push {a=8'h96, amt=3, lar=2'b10}, out_ready=1 -> out_valid after 2 edges, out_data=8'hD2, out_lar=2'b10.
//  2. Back-to-back pushes: {8'h96,2,01}, {8'h96,4,00}, {8'h80,7,01}, out_ready=1
//     -> results 8'hE5, 8'h09, 8'hFF on consecutive cycles, in order.
//  3. out_ready=0, in_valid held high -> 5 commands accepted (DEPTH+1), then in_ready=0 with count=4.
//     Then out_ready=1 -> each result drains in order and in_ready returns 1 on the first pop.
//  4. FIFO full, simultaneous in_valid and pop -> push rejected that cycle, count goes 4->3, no data loss.
//  5. Three commands in flight, flush=1 for one cycle -> next cycle count=0, out_valid=0, sh_a=0.
//     A new command afterwards gives the correct result.
//  6. rst_n dropped mid-burst, asynchronously between edges -> out_valid=0 and count=0 immediately.
//     After release, in_ready=1 and no stale result ever appears.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// shift_cmd_sequencer
//
// Command stage in front of an 8-bit combinational right barrel shifter.
// Shift commands {data, amt, lar} are queued in a DEPTH-entry FIFO. The FIFO
// head is presented to the shifter straight from storage registers, so the
// shifter operands never glitch. The shifter result is captured in an output
// register and handed to the consumer with a valid/ready handshake.
// Total in-flight capacity is DEPTH + 1 (FIFO plus the output register).
//
// Parameters
//   DEPTH      FIFO entries; power of two, 2..16
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of FIFO and output valid
//   in_valid   upstream command valid
//   in_ready   command accepted when in_valid & in_ready at the edge
//   in_a       operand to shift
//   in_amt     shift amount 0..7
//   in_lar     shifter mode: 00 logic, 01 arith, 1x rotate
//   sh_a       shifter operand (FIFO head data, 0 when FIFO empty)
//   sh_amt     shifter amount  (FIFO head amt,  0 when FIFO empty)
//   sh_lar     shifter mode    (FIFO head lar,  0 when FIFO empty)
//   sh_o       shifter result, combinational in sh_a/sh_amt/sh_lar
//   out_valid  result valid
//   out_ready  consumer takes the result when out_valid & out_ready
//   out_data   captured shifter result
//   out_lar    mode of the command that produced out_data
//   count      commands held in the FIFO (0..DEPTH), output register excluded
// ---------------------------------------------------------------------------
module shift_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [2:0] in_amt,
  input  logic [1:0] in_lar,
  output logic [7:0] sh_a,
  output logic [2:0] sh_amt,
  output logic [1:0] sh_lar,
  input  logic [7:0] sh_o,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_lar,
  output logic [4:0] count
);

  localparam int         PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FullCount = 5'(DEPTH);

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } outState_e;

  // FIFO storage, deliberately without reset: an entry is only ever read
  // after it has been written, and the sh_* outputs are masked while empty.
  logic [7:0]      memA_q   [DEPTH];
  logic [2:0]      memAmt_q [DEPTH];
  logic [1:0]      memLar_q [DEPTH];

  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [4:0]      count_q, count_d;
  outState_e       state_q, state_d;
  logic [7:0]      outData_q, outData_d;
  logic [1:0]      outLar_q, outLar_d;

  logic            fifoFull;
  logic            fifoEmpty;
  logic            push;
  logic            pop;
  logic [7:0]      headA;
  logic [2:0]      headAmt;
  logic [1:0]      headLar;

  // Full/empty come from the occupancy counter; pointer equality is ambiguous.
  assign fifoFull  = (count_q == FullCount);
  assign fifoEmpty = (count_q == 5'd0);

  // No bypass when full: a pop in the same cycle does not free a slot early.
  assign in_ready  = !fifoFull && !flush;
  assign push      = in_valid && in_ready;

  assign headA     = memA_q[rdPtr_q];
  assign headAmt   = memAmt_q[rdPtr_q];
  assign headLar   = memLar_q[rdPtr_q];

  assign sh_a      = fifoEmpty ? 8'd0 : headA;
  assign sh_amt    = fifoEmpty ? 3'd0 : headAmt;
  assign sh_lar    = fifoEmpty ? 2'd0 : headLar;

  assign out_valid = (state_q == StFull);
  assign out_data  = outData_q;
  assign out_lar   = outLar_q;
  assign count     = count_q;

  // Write the incoming command into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      memA_q[wrPtr_q]   <= in_a;
      memAmt_q[wrPtr_q] <= in_amt;
      memLar_q[wrPtr_q] <= in_lar;
    end
  end

  // Output register FSM: decides when the head is captured and popped.
  // The captured value is the shifter's response to the current head, which
  // is only valid because sh_* are driven from that same head entry.
  always_comb begin
    state_d   = state_q;
    outData_d = outData_q;
    outLar_d  = outLar_q;
    pop       = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (!fifoEmpty) begin
            pop       = 1'b1;
            outData_d = sh_o;
            outLar_d  = headLar;
            state_d   = StFull;
          end
        end
        StFull: begin
          if (out_ready) begin
            if (!fifoEmpty) begin
              pop       = 1'b1;
              outData_d = sh_o;
              outLar_d  = headLar;
            end else begin
              state_d = StEmpty;
            end
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because DEPTH
  // is a power of two. A flush discards everything that is queued.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = 5'd0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PtrW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears everything including the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= 5'd0;
      state_q   <= StEmpty;
      outData_q <= 8'd0;
      outLar_q  <= 2'd0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      outData_q <= outData_d;
      outLar_q  <= outLar_d;
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_cmd_sequencer
//
// Bench for shift_cmd_sequencer. A behavioural barrel shifter closes the
// sh_* -> sh_o loop. A queue-based reference model tracks the FIFO contents
// and the output register, and each scenario task compares the DUT against
// it (and against fixed values for the known vectors).
// ---------------------------------------------------------------------------
module tb_shift_cmd_sequencer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [2:0] amt;
    logic [1:0] lar;
  } cmd_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [2:0] in_amt;
  logic [1:0] in_lar;
  logic [7:0] sh_a;
  logic [2:0] sh_amt;
  logic [1:0] sh_lar;
  logic [7:0] sh_o;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_lar;
  logic [4:0] count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  cmd_t       mq[$];
  logic       mOutValid;
  logic [7:0] mOutData;
  logic [1:0] mOutLar;

  shift_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_lar    (in_lar),
    .sh_a      (sh_a),
    .sh_amt    (sh_amt),
    .sh_lar    (sh_lar),
    .sh_o      (sh_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lar   (out_lar),
    .count     (count)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Right barrel shifter: rotate takes the low byte of the doubled word.
  function automatic logic [7:0] shiftRef(input logic [7:0] a, input logic [2:0] amt,
                                          input logic [1:0] lar);
    logic [15:0] dbl;
    logic [7:0]  res;
    if (lar[1]) begin
      dbl = {a, a} >> amt;
      res = dbl[7:0];
    end else if (lar[0]) begin
      res = $signed(a) >>> amt;
    end else begin
      res = a >> amt;
    end
    return res;
  endfunction

  assign sh_o = shiftRef(sh_a, sh_amt, sh_lar);

  // Drive all command/handshake inputs at once.
  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [2:0] amt,
                               input logic [1:0] lar, input logic ordy, input logic fl);
    in_valid  = v;
    in_a      = a;
    in_amt    = amt;
    in_lar    = lar;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic applyRandomCmd(input logic v, input logic ordy);
    applyStimulus(v, 8'($urandom), 3'($urandom), 2'($urandom), ordy, 1'b0);
  endtask

  task automatic modelReset();
    mq.delete();
    mOutValid = 1'b0;
    mOutData  = 8'd0;
    mOutLar   = 2'd0;
  endtask

  // Advance the model by one rising edge using the current inputs, then let
  // the edge happen and settle 1 unit past it.
  task automatic tick();
    cmd_t e;
    bit   pushOk;
    bit   popOk;
    if (flush) begin
      mq.delete();
      mOutValid = 1'b0;
    end else begin
      pushOk = in_valid && (mq.size() < DEPTH);
      popOk  = (mq.size() > 0) && (!mOutValid || out_ready);
      if (popOk) begin
        e         = mq.pop_front();
        mOutValid = 1'b1;
        mOutData  = shiftRef(e.a, e.amt, e.lar);
        mOutLar   = e.lar;
      end else if (out_ready) begin
        mOutValid = 1'b0;
      end
      if (pushOk) mq.push_back({in_a, in_amt, in_lar});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    modelReset();
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: actual=%b required=0", out_valid); end
    checks++; if (out_data !== 8'd0) begin failures++; $display("[TB] FAIL reset_out_data: actual=%h required=00", out_data); end
    checks++; if (out_lar !== 2'd0) begin failures++; $display("[TB] FAIL reset_out_lar: actual=%b required=00", out_lar); end
    checks++; if ({sh_a, sh_amt, sh_lar} !== 13'd0) begin failures++; $display("[TB] FAIL reset_sh: actual=%h/%h/%h required=0/0/0", sh_a, sh_amt, sh_lar); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count: actual=%0d required=0", count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: actual=%b required=1", in_ready); end
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 8'h96, 3'd3, 2'b10, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, 1'b0);
    checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL single_count: actual=%0d required=1", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_valid: actual=%b required=0", out_valid); end
    checks++; if ({sh_a, sh_amt, sh_lar} !== {8'h96, 3'd3, 2'b10}) begin failures++; $display("[TB] FAIL single_sh: actual=%h/%h/%b required=96/3/10", sh_a, sh_amt, sh_lar); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid: actual=%b required=1", out_valid); end
    checks++; if (out_data !== 8'hD2) begin failures++; $display("[TB] FAIL single_data: actual=%h required=d2", out_data); end
    checks++; if (out_lar !== 2'b10) begin failures++; $display("[TB] FAIL single_lar: actual=%b required=10", out_lar); end
    tick();
    checks++; if (out_valid !== mOutValid) begin failures++; $display("[TB] FAIL single_drained: actual=%b required=%b", out_valid, mOutValid); end
  endtask

  task automatic test_back_to_back();
    cmd_t       cmds[3];
    logic [7:0] expData[3];
    cmds[0] = {8'h96, 3'd2, 2'b01};
    cmds[1] = {8'h96, 3'd4, 2'b00};
    cmds[2] = {8'h80, 3'd7, 2'b01};
    expData[0] = 8'hE5;
    expData[1] = 8'h09;
    expData[2] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) applyStimulus(1'b1, cmds[i].a, cmds[i].amt, cmds[i].lar, 1'b1, 1'b0);
      else       applyStimulus(1'b0, 8'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      tick();
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d]: actual=%b required=1", i - 1, out_valid); end
        checks++; if (out_data !== expData[i-1]) begin failures++; $display("[TB] FAIL b2b_data[%0d]: actual=%h required=%h", i - 1, out_data, expData[i-1]); end
        checks++; if (out_lar !== cmds[i-1].lar) begin failures++; $display("[TB] FAIL b2b_lar[%0d]: actual=%b required=%b", i - 1, out_lar, cmds[i-1].lar); end
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: actual=%b required=0", out_valid); end
  endtask

  task automatic test_fill_drain();
    int accepted = 0;
    int i;
    applyRandomCmd(1'b1, 1'b0);
    for (i = 0; i < 20; i++) begin
      if (!in_ready) break;
      accepted++;
      tick();
      applyRandomCmd(1'b1, 1'b0);
    end
    checks++; if (accepted !== DEPTH + 1) begin failures++; $display("[TB] FAIL fill_accepted: actual=%0d required=%0d", accepted, DEPTH + 1); end
    checks++; if (count !== 5'(DEPTH)) begin failures++; $display("[TB] FAIL fill_count: actual=%0d required=%0d", count, DEPTH); end
    checks++; if (out_data !== mOutData) begin failures++; $display("[TB] FAIL fill_head_result: actual=%h required=%h", out_data, mOutData); end
    // Full FIFO with a pop and a push offered: the push must be refused.
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 5'(DEPTH - 1)) begin failures++; $display("[TB] FAIL full_pop_count: actual=%0d required=%0d", count, DEPTH - 1); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_pop_in_ready: actual=%b required=1", in_ready); end
    applyStimulus(1'b0, 8'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    for (i = 0; i < 12; i++) begin
      checks++; if (out_valid !== mOutValid) begin failures++; $display("[TB] FAIL drain_valid[%0d]: actual=%b required=%b", i, out_valid, mOutValid); end
      checks++; if ({out_data, out_lar} !== {mOutData, mOutLar}) begin failures++; $display("[TB] FAIL drain_data[%0d]: actual=%h/%b required=%h/%b", i, out_data, out_lar, mOutData, mOutLar); end
      if (!mOutValid && mq.size() == 0) break;
      tick();
    end
    checks++; if (i >= 12) begin failures++; $display("[TB] FAIL drain_timeout: actual=%0d required<12", i); end
  endtask

  task automatic test_flush();
    logic [7:0] heldData;
    for (int i = 0; i < 3; i++) begin
      applyRandomCmd(1'b1, 1'b0);
      tick();
    end
    heldData = mOutData;
    applyRandomCmd(1'b1, 1'b1);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready: actual=%b required=0", in_ready); end
    tick();
    applyStimulus(1'b0, 8'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL flush_count: actual=%0d required=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid: actual=%b required=0", out_valid); end
    checks++; if (sh_a !== 8'd0) begin failures++; $display("[TB] FAIL flush_sh_a: actual=%h required=00", sh_a); end
    checks++; if (out_data !== heldData) begin failures++; $display("[TB] FAIL flush_out_data_kept: actual=%h required=%h", out_data, heldData); end
    applyRandomCmd(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    tick();
    checks++; if ({out_valid, out_data, out_lar} !== {1'b1, mOutData, mOutLar}) begin failures++; $display("[TB] FAIL flush_after: actual=%b/%h/%b required=1/%h/%b", out_valid, out_data, out_lar, mOutData, mOutLar); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      applyRandomCmd(1'b1, 1'b0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    modelReset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_valid: actual=%b required=0", out_valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL areset_count: actual=%0d required=0", count); end
    checks++; if ({sh_a, out_data} !== 16'd0) begin failures++; $display("[TB] FAIL areset_data: actual=%h/%h required=00/00", sh_a, out_data); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL areset_in_ready: actual=%b required=1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({out_valid, count} !== 6'd0) begin failures++; $display("[TB] FAIL areset_stale[%0d]: actual=%b/%0d required=0/0", i, out_valid, count); end
    end
  endtask

  task automatic test_random();
    logic [7:0] expA;
    logic [2:0] expAmt;
    logic [1:0] expLar;
    for (int i = 0; i < 400; i++) begin
      applyRandomCmd($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55);
      flush = ($urandom_range(0, 99) < 3);
      #1;
      expA   = (mq.size() > 0) ? mq[0].a   : 8'd0;
      expAmt = (mq.size() > 0) ? mq[0].amt : 3'd0;
      expLar = (mq.size() > 0) ? mq[0].lar : 2'd0;
      checks++; if (in_ready !== ((mq.size() < DEPTH) && !flush)) begin failures++; $display("[TB] FAIL rnd_in_ready[%0d]: actual=%b required=%b", i, in_ready, (mq.size() < DEPTH) && !flush); end
      checks++; if (count !== 5'(mq.size())) begin failures++; $display("[TB] FAIL rnd_count[%0d]: actual=%0d required=%0d", i, count, mq.size()); end
      checks++; if ({sh_a, sh_amt, sh_lar} !== {expA, expAmt, expLar}) begin failures++; $display("[TB] FAIL rnd_sh[%0d]: actual=%h/%h/%b required=%h/%h/%b", i, sh_a, sh_amt, sh_lar, expA, expAmt, expLar); end
      checks++; if ({out_valid, out_data, out_lar} !== {mOutValid, mOutData, mOutLar}) begin failures++; $display("[TB] FAIL rnd_out[%0d]: actual=%b/%h/%b required=%b/%h/%b", i, out_valid, out_data, out_lar, mOutValid, mOutData, mOutLar); end
      tick();
    end
    applyStimulus(1'b0, 8'd0, 3'd0, 2'd0, 1'b1, 1'b0);
  endtask

  // Safety net so the run always ends even if something stalls.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_drain();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
